// File: rtl/output_quantizer_if.sv
// Command, accumulator-diagonal and SRAM-write signal bundle for output_quantizer.
interface output_quantizer_if #(
  parameter int ARRAY_SIZE        = 256,
  parameter int ACC_WIDTH         = 32,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int INDEX_WIDTH       = 9
);
  logic                                  start;
  logic [1:0]                            data_set_in;
  logic [4:0]                            shift_amt;
  logic                                  acc_valid;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]       acc_data;
  logic                                  busy;
  logic                                  done;
  logic                                  sram_write_enable;
  logic [1:0]                            data_set;
  logic [INDEX_WIDTH-1:0]                matrix_index;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data;

  modport master (
    output start, data_set_in, shift_amt, acc_valid, acc_data,
    input  busy, done, sram_write_enable, data_set, matrix_index, quantized_data
  );

  modport slave (
    input  start, data_set_in, shift_amt, acc_valid, acc_data,
    output busy, done, sram_write_enable, data_set, matrix_index, quantized_data
  );
endinterface

// File: rtl/output_quantizer.sv
// Drains 2*ARRAY_SIZE-1 accumulator diagonals per start: round-shift, saturate, tag with index.
// Optional macro QUANT_RELU_EN clamps negative rounded values to zero before saturation.
module output_quantizer #(
  parameter int ARRAY_SIZE        = 256,
  parameter int ACC_WIDTH         = 32,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int INDEX_WIDTH       = 9
) (
  input logic              clk,
  input logic              srstn,
  output_quantizer_if.slave bus
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(2 * ARRAY_SIZE - 2);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((1 << (OUTPUT_DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;

  // Round half-up toward +inf: add half an LSB of the result, then arithmetic shift.
  function automatic logic signed [ACC_WIDTH:0] round_shift(input logic [ACC_WIDTH-1:0] acc,
                                                            input logic [4:0] sh);
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] sum;
    if (sh != 5'd0) rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1);
    else            rnd = '0;
    sum = {acc[ACC_WIDTH-1], acc} + rnd;
    return sum >>> sh;
  endfunction

  function automatic logic [OUTPUT_DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] v);
    logic signed [ACC_WIDTH:0] t;
    t = v;
`ifdef QUANT_RELU_EN
    if (t[ACC_WIDTH]) t = '0;
    else              t = v;
`endif
    if (t > SAT_MAX)      return SAT_MAX[OUTPUT_DATA_WIDTH-1:0];
    else if (t < SAT_MIN) return SAT_MIN[OUTPUT_DATA_WIDTH-1:0];
    else                  return t[OUTPUT_DATA_WIDTH-1:0];
  endfunction

  state_t                    state_r, next_state_s;
  logic                      start_acc_s, accept_s;
  logic                      busy_r, done_r, wen_r;
  logic [1:0]                data_set_r;
  logic [4:0]                shift_r;
  logic [INDEX_WIDTH-1:0]    cnt_r, s1_index_r, index_r;
  logic                      s1_valid_r, s1_last_r;
  logic [ARRAY_SIZE-1:0][ACC_WIDTH:0]           rounded_s, s1_data_r;
  logic [ARRAY_SIZE-1:0][OUTPUT_DATA_WIDTH-1:0] sat_s, q_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!srstn) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state decode and beat acceptance.
  always_comb begin
    next_state_s = state_r;
    start_acc_s  = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          start_acc_s  = 1'b1;
          next_state_s = DRAIN;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRAIN: begin
        if (bus.acc_valid) begin
          accept_s = 1'b1;
          if (cnt_r == LAST_IDX) next_state_s = FLUSH;
          else                   next_state_s = DRAIN;
        end else begin
          next_state_s = DRAIN;
        end
      end
      FLUSH: begin
        // done_r marks the last beat sitting in the output stage: pipeline empties now.
        if (done_r) next_state_s = IDLE;
        else        next_state_s = FLUSH;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Latched command fields, busy flag and beat counter.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      busy_r     <= 1'b0;
      data_set_r <= 2'd0;
      shift_r    <= 5'd0;
      cnt_r      <= '0;
    end else if (start_acc_s) begin
      busy_r     <= 1'b1;
      data_set_r <= bus.data_set_in;
      shift_r    <= bus.shift_amt;
      cnt_r      <= '0;
    end else if (accept_s) begin
      cnt_r      <= cnt_r + INDEX_WIDTH'(1);
    end else if (state_r == FLUSH && done_r) begin
      busy_r     <= 1'b0;
      data_set_r <= 2'd0;
    end
  end

  // Per-lane rounding shift and saturation.
  always_comb begin
    rounded_s = '0;
    sat_s     = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      rounded_s[i] = round_shift(bus.acc_data[i*ACC_WIDTH +: ACC_WIDTH], shift_r);
      sat_s[i]     = saturate(s1_data_r[i]);
    end
  end

  // Stage 1: rounded lanes tagged with index.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_index_r <= '0;
      s1_data_r  <= '0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= (cnt_r == LAST_IDX);
      s1_index_r <= cnt_r;
      s1_data_r  <= rounded_s;
    end else begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_index_r <= '0;
      s1_data_r  <= '0;
    end
  end

  // Stage 2: saturated output beat; all fields zero when idle.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      wen_r   <= 1'b0;
      done_r  <= 1'b0;
      index_r <= '0;
      q_r     <= '0;
    end else if (s1_valid_r) begin
      wen_r   <= 1'b1;
      done_r  <= s1_last_r;
      index_r <= s1_index_r;
      q_r     <= sat_s;
    end else begin
      wen_r   <= 1'b0;
      done_r  <= 1'b0;
      index_r <= '0;
      q_r     <= '0;
    end
  end

  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.sram_write_enable = wen_r;
  assign bus.data_set          = data_set_r;
  assign bus.matrix_index      = index_r;
  assign bus.quantized_data    = q_r;

endmodule

// File: tb/tb_output_quantizer.sv
// Directed self-checking bench for output_quantizer: rounding, saturation, drains, bubbles, abuse, reset.
module tb_output_quantizer;
  localparam int N    = 256;
  localparam int AW   = 32;
  localparam int OW   = 16;
  localparam int IW   = 9;
  localparam int LAST = 2 * N - 2;

  logic clk = 1'b0;
  logic srstn;

  output_quantizer_if #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUTPUT_DATA_WIDTH(OW), .INDEX_WIDTH(IW)) bus ();
  output_quantizer #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUTPUT_DATA_WIDTH(OW), .INDEX_WIDTH(IW))
    dut (.clk(clk), .srstn(srstn), .bus(bus));

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic d1_v = 1'b0, d2_v = 1'b0, d1_l = 1'b0, d2_l = 1'b0;
  int   d1_i = 0, d2_i = 0;
  int   nbeat  = 0;
  int   cur_sh = 0;
  logic [15:0] exp_l [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the beat driven two cycles ago, then drive the next inputs.
  task automatic step(input logic st, input logic v, input logic acc);
    @(negedge clk);
    if (d2_v) begin
      check("wen", 32'(bus.sram_write_enable), 32'd1);
      check("index", 32'(bus.matrix_index), 32'(d2_i));
      check("done", 32'(bus.done), 32'(d2_l));
      for (int k = 0; k < 4; k++) check("lane", 32'(bus.quantized_data[k*OW +: OW]), 32'(exp_l[k]));
      check("lane4", 32'(bus.quantized_data[4*OW +: OW]), 32'(d2_i));
      check("upper_zero", 32'(|bus.quantized_data[N*OW-1:5*OW]), 32'd0);
    end else begin
      check("wen_idle", 32'(bus.sram_write_enable), 32'd0);
      check("index_idle", 32'(bus.matrix_index), 32'd0);
      check("done_idle", 32'(bus.done), 32'd0);
      check("q_idle", 32'(|bus.quantized_data), 32'd0);
    end
    d2_v = d1_v; d2_i = d1_i; d2_l = d1_l;
    bus.start     = st;
    bus.acc_valid = v;
    bus.acc_data[4*AW +: AW] = 32'(nbeat << cur_sh);
    if (acc) begin
      d1_v = 1'b1; d1_i = nbeat; d1_l = (nbeat == LAST); nbeat++;
    end else begin
      d1_v = 1'b0; d1_i = 0; d1_l = 1'b0;
    end
  endtask

  task automatic start_drain(input logic [1:0] ds, input logic [4:0] sh,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    step(1'b1, 1'b0, 1'b0);
    check("busy_before_start", 32'(bus.busy), 32'd0);
    check("data_set_idle", 32'(bus.data_set), 32'd0);
    bus.data_set_in = ds;
    bus.shift_amt   = sh;
    bus.acc_data    = '0;
    bus.acc_data[0*AW +: AW] = a0;
    bus.acc_data[1*AW +: AW] = a1;
    bus.acc_data[2*AW +: AW] = a2;
    bus.acc_data[3*AW +: AW] = a3;
    exp_l[0] = e0; exp_l[1] = e1; exp_l[2] = e2; exp_l[3] = e3;
    cur_sh = int'(sh);
    nbeat  = 0;
  endtask

  task automatic run_beats(input bit bubbles, input int abuse_at, input int stop_at, input logic [1:0] ds);
    int c;
    c = 0;
    while (nbeat < stop_at) begin
      if (bubbles && (c % 3 == 2)) begin
        step(1'b0, 1'b0, 1'b0);
      end else if (nbeat == abuse_at) begin
        step(1'b1, 1'b1, 1'b1);
        bus.data_set_in = 2'd2;
        bus.shift_amt   = 5'd0;
      end else begin
        step(1'b0, 1'b1, 1'b1);
      end
      check("busy_drain", 32'(bus.busy), 32'd1);
      check("data_set_drain", 32'(bus.data_set), 32'(ds));
      c++;
    end
  endtask

  task automatic finish_drain();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("busy_at_done", 32'(bus.busy), 32'd1);
  endtask

  logic [15:0] t1 [4];
  logic [15:0] t2 [4];

  initial begin
`ifdef QUANT_RELU_EN
    t1[0] = 16'h0123; t1[1] = 16'h0002; t1[2] = 16'h0000; t1[3] = 16'h0000;
    t2[0] = 16'h7FFF; t2[1] = 16'h0000; t2[2] = 16'h7FFF; t2[3] = 16'h0000;
`else
    t1[0] = 16'h0123; t1[1] = 16'h0002; t1[2] = 16'hFFFF; t1[3] = 16'h0000;
    t2[0] = 16'h7FFF; t2[1] = 16'h8000; t2[2] = 16'h7FFF; t2[3] = 16'hFFE8;
`endif
    srstn           = 1'b0;
    bus.start       = 1'b0;
    bus.data_set_in = 2'd0;
    bus.shift_amt   = 5'd0;
    bus.acc_valid   = 1'b0;
    bus.acc_data    = '0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_data_set", 32'(bus.data_set), 32'd0);
    srstn = 1'b1;

    // acc_valid while idle must not write.
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Full drain with rounding vectors and an ignored start at beat 100.
    start_drain(2'd1, 5'd4, 32'h00001234, 32'h00000018, 32'hFFFFFFE8, 32'hFFFFFFF8,
                t1[0], t1[1], t1[2], t1[3]);
    run_beats(1'b0, 100, LAST + 1, 2'd1);
    finish_drain();

    // Back-to-back drain with saturation vectors and a bubble every third cycle.
    start_drain(2'd2, 5'd0, 32'h7FFFFFFF, 32'h80000000, 32'h00007FFF, 32'hFFFFFFE8,
                t2[0], t2[1], t2[2], t2[3]);
    run_beats(1'b1, -1, LAST + 1, 2'd2);
    finish_drain();

    // Reset in the middle of a drain.
    start_drain(2'd3, 5'd4, 32'h00001234, 32'h00000018, 32'hFFFFFFE8, 32'hFFFFFFF8,
                t1[0], t1[1], t1[2], t1[3]);
    run_beats(1'b0, -1, 200, 2'd3);
    step(1'b0, 1'b0, 1'b0);
    srstn = 1'b0;
    d1_v = 1'b0; d1_l = 1'b0; d1_i = 0;
    d2_v = 1'b0; d2_l = 1'b0; d2_i = 0;
    step(1'b0, 1'b1, 1'b0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data_set", 32'(bus.data_set), 32'd0);
    srstn = 1'b1;
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Fresh drain after reset restarts from index 0.
    start_drain(2'd1, 5'd4, 32'h00001234, 32'h00000018, 32'hFFFFFFE8, 32'hFFFFFFF8,
                t1[0], t1[1], t1[2], t1[3]);
    run_beats(1'b0, -1, LAST + 1, 2'd1);
    finish_drain();
    step(1'b0, 1'b0, 1'b0);
    check("final_busy", 32'(bus.busy), 32'd0);
    check("final_data_set", 32'(bus.data_set), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
